// File: rtl/pio_pkg.sv
// Shared constants for the edge-capturing input PIO: register word
// addresses and the EDGE_TYPE capture-mode encodings.
package pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE    = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_sync_bit.sv
// One input bit: SYNC_STAGES-deep synchroniser, plus an optional
// stable-sample debouncer when PIO_IN_DEBOUNCE_EN is defined.
module pio_sync_bit #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic data_val
);

  logic [SYNC_STAGES-1:0] sff;
  logic                   sync_in;

  // Shift the raw pin through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (!reset_n) sff <= '0;
    else          sff <= {sff[SYNC_STAGES-2:0], pin};
  end

  assign sync_in = sff[SYNC_STAGES-1];

`ifdef PIO_IN_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          deb;

  // Accept a new level only after it has differed from the current
  // debounced value for DEBOUNCE_CYCLES consecutive samples.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (sync_in == deb) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      deb <= sync_in;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign data_val = deb;
`else
  assign data_val = sync_in;
`endif

endmodule

// File: rtl/pio_in_edge.sv
// Avalon-MM input PIO with per-bit edge capture (write-1-to-clear),
// interrupt mask and level irq. Optional debounce: PIO_IN_DEBOUNCE_EN.
module pio_in_edge
  import pio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int EDGE_TYPE       = EDGE_RISE,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int ARM = SYNC_STAGES + 1;
  localparam int AW  = $clog2(ARM + 1);

  logic [WIDTH-1:0] data_val, prev, sel, edgecapture, irqmask;
  logic [WIDTH-1:0] clr, ec_next, mask_next;
  logic [AW-1:0]    arm_cnt;
  logic             armed, wr, unused_wd;
  logic [31:0]      rd_mux;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_sync_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk     (clk),
      .reset_n (reset_n),
      .pin     (in_port[i]),
      .data_val(data_val[i])
    );
  end

  // Upper writedata bits never reach any state.
  assign unused_wd = ^writedata;

  // Hold off edge detection until the synchroniser has refilled after reset.
  always_ff @(posedge clk) begin
    if (!reset_n)   arm_cnt <= '0;
    else if (!armed) arm_cnt <= arm_cnt + 1'b1;
  end

  assign armed = (arm_cnt == AW'(ARM));

  // Select which transitions count as captured edges.
  always_comb begin
    sel = '0;
    if (armed) begin
      case (EDGE_TYPE)
        EDGE_FALL: sel = ~data_val & prev;
        EDGE_ANY:  sel = data_val ^ prev;
        default:   sel = data_val & ~prev;
      endcase
    end
  end

  // Next-state for the writable registers; a new edge beats a same-cycle clear.
  always_comb begin
    wr        = chipselect & ~write_n;
    clr       = (wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
    mask_next = (wr && address == ADDR_IRQMASK) ? writedata[WIDTH-1:0] : irqmask;
    ec_next   = (edgecapture & ~clr) | sel;
  end

  // Read mux, zero-extended; sampled every cycle regardless of chipselect.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = data_val;
      ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
      ADDR_EDGE:    rd_mux[WIDTH-1:0] = edgecapture;
      default:      rd_mux = '0;
    endcase
  end

  // Register state, read data and the level interrupt.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev        <= '0;
      edgecapture <= '0;
      irqmask     <= '0;
      readdata    <= '0;
      irq         <= 1'b0;
    end else begin
      prev        <= data_val;
      edgecapture <= ec_next;
      irqmask     <= mask_next;
      readdata    <= rd_mux;
      irq         <= |(ec_next & mask_next);
    end
  end

endmodule

// File: tb/tb_pio_in_edge.sv
// Directed bench: one rising-edge and one any-edge PIO share the bus and pins.
module tb_pio_in_edge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] rd_rise, rd_any;
  logic        irq_rise, irq_any;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pio_in_edge #(.WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(2)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_rise), .irq(irq_rise)
  );

  pio_in_edge #(.WIDTH(8), .EDGE_TYPE(2), .SYNC_STAGES(2)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_any), .irq(irq_any)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [1:0] a);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    tick();
    chipselect = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = 8'hFF;
    tick(2);
    chk("reset rd rise", rd_rise, 32'h0);
    chk("reset rd any", rd_any, 32'h0);
    chk("reset irq rise", {31'b0, irq_rise}, 32'h0);
    chk("reset irq any", {31'b0, irq_any}, 32'h0);

    // Pins high out of reset: no spurious edge after arming.
    reset_n = 1'b1;
    tick(5);
    bus_rd(2'd0);
    chk("data hi rise", rd_rise, 32'h0000_00FF);
    chk("data hi any", rd_any, 32'h0000_00FF);
    bus_rd(2'd3);
    chk("no edge rise", rd_rise, 32'h0);
    chk("no edge any", rd_any, 32'h0);

    // All pins fall: only the any-edge unit captures.
    in_port = 8'h00;
    tick(5);
    bus_rd(2'd3);
    chk("fall rise", rd_rise, 32'h0);
    chk("fall any", rd_any, 32'h0000_00FF);
    bus_wr(2'd3, 32'hFF);
    bus_rd(2'd3);
    chk("clr any", rd_any, 32'h0);

    // Mask bit 0, then a rising edge: irq lands on the 3rd edge after the change.
    bus_wr(2'd2, 32'h01);
    bus_rd(2'd2);
    chk("mask rd", rd_rise, 32'h01);
    in_port[0] = 1'b1;
    tick(2);
    chk("irq early rise", {31'b0, irq_rise}, 32'h0);
    chk("irq early any", {31'b0, irq_any}, 32'h0);
    tick();
    chk("irq rise", {31'b0, irq_rise}, 32'h1);
    chk("irq any", {31'b0, irq_any}, 32'h1);
    bus_rd(2'd3);
    chk("cap rise", rd_rise, 32'h01);

    // Write-1-to-clear drops irq right after the write edge.
    bus_wr(2'd3, 32'h01);
    chk("irq clr rise", {31'b0, irq_rise}, 32'h0);
    chk("irq clr any", {31'b0, irq_any}, 32'h0);
    bus_rd(2'd3);
    chk("ec clr rise", rd_rise, 32'h0);

    // Falling edge on bit 0 distinguishes the two modes.
    in_port[0] = 1'b0;
    tick(4);
    chk("fall irq rise", {31'b0, irq_rise}, 32'h0);
    chk("fall irq any", {31'b0, irq_any}, 32'h1);
    bus_wr(2'd3, 32'h01);

    // Clear coinciding with a new edge: the edge wins.
    in_port[0] = 1'b1;
    tick(2);
    bus_wr(2'd3, 32'h01);
    bus_rd(2'd3);
    chk("edge wins rise", rd_rise, 32'h01);
    chk("edge wins any", rd_any, 32'h01);
    chk("edge wins irq", {31'b0, irq_rise}, 32'h1);
    bus_wr(2'd3, 32'h01);

    // Bit 3 pulse with mask 0, then unmask.
    bus_wr(2'd2, 32'h00);
    in_port = 8'h09;
    tick(4);
    in_port = 8'h01;
    tick(4);
    bus_rd(2'd3);
    chk("b3 rise", rd_rise, 32'h08);
    chk("b3 any", rd_any, 32'h08);
    chk("b3 irq masked", {31'b0, irq_any}, 32'h0);
    bus_wr(2'd2, 32'h08);
    chk("unmask irq rise", {31'b0, irq_rise}, 32'h1);
    chk("unmask irq any", {31'b0, irq_any}, 32'h1);

    // Read-only data, reserved word, ignored upper writedata bits.
    bus_wr(2'd0, 32'h55);
    bus_rd(2'd0);
    chk("data ro", rd_rise, 32'h01);
    bus_rd(2'd1);
    chk("rsvd", rd_any, 32'h0);
    bus_wr(2'd2, 32'hFFFF_FF08);
    bus_rd(2'd2);
    chk("mask width", rd_rise, 32'h08);

    // Mid-operation reset with captures pending and all bits unmasked.
    bus_wr(2'd3, 32'hFF);
    in_port = 8'hA5;
    tick(5);
    bus_wr(2'd2, 32'hFF);
    bus_rd(2'd3);
    chk("pre rst ec rise", rd_rise, 32'hA4);
    chk("pre rst ec any", rd_any, 32'hA4);
    chk("pre rst irq", {31'b0, irq_any}, 32'h1);
    reset_n = 1'b0;
    tick();
    chk("mid rst rd", rd_rise, 32'h0);
    chk("mid rst irq rise", {31'b0, irq_rise}, 32'h0);
    chk("mid rst irq any", {31'b0, irq_any}, 32'h0);
    reset_n = 1'b1;
    tick(6);
    bus_rd(2'd3);
    chk("post rst ec rise", rd_rise, 32'h0);
    chk("post rst ec any", rd_any, 32'h0);
    bus_rd(2'd2);
    chk("post rst mask", rd_any, 32'h0);
    bus_rd(2'd0);
    chk("post rst data", rd_rise, 32'hA5);
    chk("post rst irq", {31'b0, irq_any | irq_rise}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
